// File: rtl/snake_body_if.sv
// snake_body_if: move/grow requests in; head, tail-clear, length, ready, moved and dead status out
interface snake_body_if;
  logic       step;
  logic [1:0] dir_in;
  logic       grow;
  logic [7:0] pos;
  logic [7:0] tailPos;
  logic [7:0] length;
  logic       ready;
  logic       moved;
  logic       dead;
  modport master (output step, dir_in, grow, input pos, tailPos, length, ready, moved, dead);
  modport slave (input step, dir_in, grow, output pos, tailPos, length, ready, moved, dead);
endinterface

// File: rtl/snake_body.sv
// snake_body: snake head mover with circular body buffer; clk/rst plus bus (step, dir_in, grow -> pos, tailPos, length, ready, moved, dead)
module snake_body #(
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3
) (
  input logic        clk,
  input logic        rst,
  snake_body_if.slave bus
);
  localparam int PW = $clog2(MAX_LEN);
  typedef enum logic [1:0] {INIT, RUN, DEAD} state_t;
  state_t         state_q;
  logic [7:0]     mem_q [MAX_LEN];
  logic [PW-1:0]  rd_q, wr_q;
  logic [127:0]   occ_q;
  logic [1:0]     dir_q, dir_d;
  logic           grow_pend_q, ready_q, moved_q, dead_q;
  logic [7:0]     pos_q, tail_q, len_q, head_d, tail_cell, init_cell;
  logic [2:0]     row_d;
  logic [3:0]     col_d;
  logic           do_grow, hit;
  assign dir_d     = (bus.dir_in == (dir_q ^ 2'b10)) ? dir_q : bus.dir_in;
  assign row_d     = pos_q[6:4] + (dir_d == 2'd1 ? 3'd1 : dir_d == 2'd3 ? 3'd7 : 3'd0);
  assign col_d     = pos_q[3:0] + (dir_d == 2'd0 ? 4'd1 : dir_d == 2'd2 ? 4'd15 : 4'd0);
  assign head_d    = {1'b0, row_d, col_d};
  assign tail_cell = mem_q[rd_q];
  assign init_cell = {4'h3, len_q[3:0]};
  assign do_grow   = (grow_pend_q | bus.grow) && len_q < 8'(MAX_LEN);
  // the tail cell only counts as free when it is actually popped by this move
  assign hit       = occ_q[head_d[6:0]] && !(head_d == tail_cell && !do_grow);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      pos_q       <= 8'h30;
      tail_q      <= 8'h30;
      len_q       <= 8'd0;
      ready_q     <= 1'b0;
      moved_q     <= 1'b0;
      dead_q      <= 1'b0;
      dir_q       <= 2'd0;
      grow_pend_q <= 1'b0;
      rd_q        <= '0;
      wr_q        <= '0;
      occ_q       <= '0;
    end else begin
      moved_q <= 1'b0;
      case (state_q)
        INIT: begin
          mem_q[wr_q]             <= init_cell;
          wr_q                    <= wr_q + PW'(1);
          occ_q[init_cell[6:0]]   <= 1'b1;
          pos_q                   <= init_cell;
          tail_q                  <= init_cell;
          len_q                   <= len_q + 8'd1;
          grow_pend_q             <= grow_pend_q | bus.grow;
          if (len_q == 8'(INIT_LEN - 1)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.step) begin
            dir_q       <= dir_d;
            grow_pend_q <= 1'b0;
            if (hit) begin
              state_q <= DEAD;
              dead_q  <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              mem_q[wr_q] <= head_d;
              wr_q        <= wr_q + PW'(1);
              pos_q       <= head_d;
              moved_q     <= 1'b1;
              if (do_grow) begin
                len_q  <= len_q + 8'd1;
                tail_q <= head_d;
              end else begin
                rd_q                   <= rd_q + PW'(1);
                occ_q[tail_cell[6:0]]  <= 1'b0;
                tail_q                 <= tail_cell;
              end
              // set after the clear so a head entering the vacated tail stays occupied
              occ_q[head_d[6:0]] <= 1'b1;
            end
          end else if (bus.grow) begin
            grow_pend_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
  assign bus.pos     = pos_q;
  assign bus.tailPos = tail_q;
  assign bus.length  = len_q;
  assign bus.ready   = ready_q;
  assign bus.moved   = moved_q;
  assign bus.dead    = dead_q;
endmodule
